lr_pkt_arbiter: RTL and testbench

Packet-atomic two-port arbiter for the 134-bit UM/LCM metadata bus. Port 0 carries pass-through datapath packets; port 1 carries locally generated management packets (beacon reports, update replies). The block grants one source at a time and forwards its packet unbroken onto a single output bus. It includes a stall watchdog that closes off abandoned packets and per-port statistics. It sits between the LCM message sources and the downstream lupdate stage.

---
 rtl/lr_pkt_arbiter_if.sv | 42 ++++
 rtl/lr_pkt_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_lr_pkt_arbiter.sv | 388 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lr_pkt_arbiter_if.sv
// Bundle of the two source ports, the forwarded output bus and the statistics
// of lr_pkt_arbiter. The arbiter uses the slave modport; sources/sinks use master.
interface lr_pkt_arbiter_if;
    logic         p0_req;
    logic         p1_req;
    logic         p0_gnt;
    logic         p1_gnt;
    logic         p0_data_wr;
    logic [133:0] p0_data;
    logic         p0_data_valid_wr;
    logic         p0_data_valid;
    logic         p1_data_wr;
    logic [133:0] p1_data;
    logic         p1_data_valid_wr;
    logic         p1_data_valid;
    logic         out_data_wr;
    logic [133:0] out_data;
    logic         out_data_valid_wr;
    logic         out_data_valid;
    logic         arb_busy;
    logic [31:0]  p0_pkt_cnt;
    logic [31:0]  p1_pkt_cnt;
    logic [15:0]  abort_cnt;

    modport master (
        output p0_req, p1_req,
        output p0_data_wr, p0_data, p0_data_valid_wr, p0_data_valid,
        output p1_data_wr, p1_data, p1_data_valid_wr, p1_data_valid,
        input  p0_gnt, p1_gnt,
        input  out_data_wr, out_data, out_data_valid_wr, out_data_valid,
        input  arb_busy, p0_pkt_cnt, p1_pkt_cnt, abort_cnt
    );

    modport slave (
        input  p0_req, p1_req,
        input  p0_data_wr, p0_data, p0_data_valid_wr, p0_data_valid,
        input  p1_data_wr, p1_data, p1_data_valid_wr, p1_data_valid,
        output p0_gnt, p1_gnt,
        output out_data_wr, out_data, out_data_valid_wr, out_data_valid,
        output arb_busy, p0_pkt_cnt, p1_pkt_cnt, abort_cnt
    );
endinterface

// File: rtl/lr_pkt_arbiter.sv
// Packet-atomic two-port arbiter for the 134-bit UM/LCM metadata bus with stall
// watchdog and per-port statistics. Define LR_ARB_STRICT_PRIO_EN for port-1 priority.
module lr_pkt_arbiter #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    lr_pkt_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_XFER  = 2'd2,
        S_ABORT = 2'd3
    } state_t;

    localparam logic [1:0] TAG_HEAD = 2'b01;
    localparam logic [1:0] TAG_TAIL = 2'b10;
    localparam logic [7:0] LP_STALL_LAST = 8'(TIMEOUT - 1);

    state_t       r_state;
    state_t       w_state_nxt;
    logic         r_port;
    logic         w_port_nxt;
    logic         r_last_srv;
    logic         w_last_srv_nxt;
    logic [1:0]   r_gnt;
    logic [1:0]   w_gnt_nxt;
    logic [7:0]   r_stall;
    logic [7:0]   w_stall_nxt;
    logic         r_out_wr;
    logic         w_out_wr_nxt;
    logic [133:0] r_out_data;
    logic [133:0] w_out_data_nxt;
    logic         r_out_vwr;
    logic         w_out_vwr_nxt;
    logic         r_out_v;
    logic         w_out_v_nxt;
    logic [31:0]  r_p0_cnt;
    logic [31:0]  r_p1_cnt;
    logic [15:0]  r_abort_cnt;
    logic         w_p0_inc;
    logic         w_p1_inc;
    logic         w_abort_inc;
    logic         w_pick;

    logic         w_sel_req;
    logic         w_sel_wr;
    logic [133:0] w_sel_data;
    logic         w_sel_vwr;
    logic         w_sel_v;

    // Only the granted port is ever looked at outside IDLE.
    assign w_sel_req  = r_port ? bus.p1_req           : bus.p0_req;
    assign w_sel_wr   = r_port ? bus.p1_data_wr       : bus.p0_data_wr;
    assign w_sel_data = r_port ? bus.p1_data          : bus.p0_data;
    assign w_sel_vwr  = r_port ? bus.p1_data_valid_wr : bus.p0_data_valid_wr;
    assign w_sel_v    = r_port ? bus.p1_data_valid    : bus.p0_data_valid;

    always_comb begin
        w_state_nxt    = r_state;
        w_port_nxt     = r_port;
        w_last_srv_nxt = r_last_srv;
        w_gnt_nxt      = r_gnt;
        w_stall_nxt    = r_stall;
        w_out_wr_nxt   = 1'b0;
        w_out_data_nxt = '0;
        w_out_vwr_nxt  = 1'b0;
        w_out_v_nxt    = 1'b0;
        w_p0_inc       = 1'b0;
        w_p1_inc       = 1'b0;
        w_abort_inc    = 1'b0;
        w_pick         = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (bus.p0_req || bus.p1_req) begin
                    if (bus.p0_req && bus.p1_req) begin
`ifdef LR_ARB_STRICT_PRIO_EN
                        w_pick = 1'b1;
`else
                        w_pick = ~r_last_srv;
`endif
                    end else begin
                        w_pick = bus.p1_req;
                    end
                    w_port_nxt  = w_pick;
                    w_gnt_nxt   = w_pick ? 2'b10 : 2'b01;
                    w_stall_nxt = '0;
                    w_state_nxt = S_WAIT;
                end
            end

            S_WAIT: begin
                if (w_sel_wr && (w_sel_data[133:132] == TAG_HEAD)) begin
                    w_out_wr_nxt   = 1'b1;
                    w_out_data_nxt = w_sel_data;
                    w_out_vwr_nxt  = w_sel_vwr;
                    w_out_v_nxt    = w_sel_v;
                    w_stall_nxt    = '0;
                    w_state_nxt    = S_XFER;
                end else if (!w_sel_req || (r_stall == LP_STALL_LAST)) begin
                    // A withdrawn request is not an abort, even on the timeout cycle.
                    w_gnt_nxt   = 2'b00;
                    w_state_nxt = S_IDLE;
                    w_abort_inc = w_sel_req;
                end else begin
                    w_stall_nxt = r_stall + 8'd1;
                end
            end

            S_XFER: begin
                if (w_sel_wr) begin
                    w_out_wr_nxt   = 1'b1;
                    w_out_data_nxt = w_sel_data;
                    w_out_vwr_nxt  = w_sel_vwr;
                    w_out_v_nxt    = w_sel_v;
                    w_stall_nxt    = '0;
                    if (w_sel_data[133:132] == TAG_TAIL) begin
                        w_gnt_nxt      = 2'b00;
                        w_last_srv_nxt = r_port;
                        w_p0_inc       = ~r_port;
                        w_p1_inc       = r_port;
                        w_state_nxt    = S_IDLE;
                    end
                end else if (r_stall == LP_STALL_LAST) begin
                    w_gnt_nxt   = 2'b00;
                    w_state_nxt = S_ABORT;
                end else begin
                    w_stall_nxt = r_stall + 8'd1;
                end
            end

            S_ABORT: begin
                // Synthetic tail marked discard so downstream drops the fragment.
                w_out_wr_nxt   = 1'b1;
                w_out_data_nxt = {TAG_TAIL, 132'd0};
                w_out_vwr_nxt  = 1'b1;
                w_out_v_nxt    = 1'b0;
                w_abort_inc    = 1'b1;
                w_last_srv_nxt = r_port;
                w_state_nxt    = S_IDLE;
            end

            default: begin
                w_gnt_nxt   = 2'b00;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_port     <= 1'b0;
            r_last_srv <= 1'b1;
            r_gnt      <= '0;
            r_stall    <= '0;
            r_out_wr   <= 1'b0;
            r_out_data <= '0;
            r_out_vwr  <= 1'b0;
            r_out_v    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_port     <= w_port_nxt;
            r_last_srv <= w_last_srv_nxt;
            r_gnt      <= w_gnt_nxt;
            r_stall    <= w_stall_nxt;
            r_out_wr   <= w_out_wr_nxt;
            r_out_data <= w_out_data_nxt;
            r_out_vwr  <= w_out_vwr_nxt;
            r_out_v    <= w_out_v_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p0_cnt    <= '0;
            r_p1_cnt    <= '0;
            r_abort_cnt <= '0;
        end else begin
            if (w_p0_inc) begin
                r_p0_cnt <= r_p0_cnt + 32'd1;
            end
            if (w_p1_inc) begin
                r_p1_cnt <= r_p1_cnt + 32'd1;
            end
            if (w_abort_inc && (r_abort_cnt != '1)) begin
                r_abort_cnt <= r_abort_cnt + 16'd1;
            end
        end
    end

    assign bus.p0_gnt            = r_gnt[0];
    assign bus.p1_gnt            = r_gnt[1];
    assign bus.out_data_wr       = r_out_wr;
    assign bus.out_data          = r_out_data;
    assign bus.out_data_valid_wr = r_out_vwr;
    assign bus.out_data_valid    = r_out_v;
    assign bus.arb_busy          = (r_state != S_IDLE);
    assign bus.p0_pkt_cnt        = r_p0_cnt;
    assign bus.p1_pkt_cnt        = r_p1_cnt;
    assign bus.abort_cnt         = r_abort_cnt;

endmodule

// File: tb/tb_lr_pkt_arbiter.sv
// Directed self-checking bench for lr_pkt_arbiter (TIMEOUT = 16).
module tb_lr_pkt_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    lr_pkt_arbiter_if bus ();

    lr_pkt_arbiter #(.TIMEOUT(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [133:0] mkw(input logic [1:0] tag, input logic [31:0] id);
        return {tag, id, ~id, 68'h5A5A_0000_1234_ABCD_9};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int port, input logic wr, input logic [133:0] d,
                         input logic vwr, input logic v);
        if (port == 0) begin
            bus.p0_data_wr       = wr;
            bus.p0_data          = d;
            bus.p0_data_valid_wr = vwr;
            bus.p0_data_valid    = v;
        end else begin
            bus.p1_data_wr       = wr;
            bus.p1_data          = d;
            bus.p1_data_valid_wr = vwr;
            bus.p1_data_valid    = v;
        end
    endtask

    task automatic clear_inputs();
        bus.p0_req = 1'b0;
        bus.p1_req = 1'b0;
        drive(0, 1'b0, '0, 1'b0, 1'b0);
        drive(1, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) tick();
        n_tests++;
        if ({bus.p0_gnt, bus.p1_gnt, bus.out_data_wr, bus.out_data_valid_wr,
             bus.out_data_valid, bus.arb_busy} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 000000", {bus.p0_gnt, bus.p1_gnt,
                     bus.out_data_wr, bus.out_data_valid_wr, bus.out_data_valid, bus.arb_busy});
        end
        n_tests++;
        if (bus.out_data !== 134'd0) begin
            n_fail++;
            $display("FAIL reset_data: got %h expected 0", bus.out_data);
        end
        n_tests++;
        if ({bus.p0_pkt_cnt, bus.p1_pkt_cnt, bus.abort_cnt} !== 80'd0) begin
            n_fail++;
            $display("FAIL reset_cnt: got %h expected 0", {bus.p0_pkt_cnt, bus.p1_pkt_cnt, bus.abort_cnt});
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        logic [133:0] w [4];
        int gcnt;
        do_reset();
        w[0] = mkw(2'b01, 32'h1000);
        w[1] = mkw(2'b11, 32'h1001);
        w[2] = mkw(2'b11, 32'h1002);
        w[3] = mkw(2'b10, 32'h1003);
        bus.p0_req = 1'b1;
        tick();
        gcnt = int'(bus.p0_gnt);
        n_tests++;
        if ({bus.p1_gnt, bus.p0_gnt} !== 2'b01) begin
            n_fail++;
            $display("FAIL single_grant: got %b expected 01", {bus.p1_gnt, bus.p0_gnt});
        end
        tick();
        gcnt += int'(bus.p0_gnt);
        n_tests++;
        if (bus.out_data_wr !== 1'b0) begin
            n_fail++;
            $display("FAIL single_wait_quiet: got wr=%b expected 0", bus.out_data_wr);
        end
        for (int i = 0; i < 4; i++) begin
            drive(0, 1'b1, w[i], i == 3, i == 3);
            if (i == 3) bus.p0_req = 1'b0;
            tick();
            gcnt += int'(bus.p0_gnt);
            n_tests++;
            if (bus.out_data_wr !== 1'b1 || bus.out_data !== w[i] ||
                {bus.out_data_valid_wr, bus.out_data_valid} !== {i == 3, i == 3}) begin
                n_fail++;
                $display("FAIL single_word%0d: got wr=%b data=%h vv=%b expected wr=1 data=%h vv=%b",
                         i, bus.out_data_wr, bus.out_data, {bus.out_data_valid_wr, bus.out_data_valid},
                         w[i], {i == 3, i == 3});
            end
        end
        drive(0, 1'b0, '0, 1'b0, 1'b0);
        n_tests++;
        if (gcnt != 5 || bus.p0_pkt_cnt !== 32'd1 || bus.arb_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_end: got gnt_cycles=%0d cnt=%0d busy=%b expected 5 1 0",
                     gcnt, bus.p0_pkt_cnt, bus.arb_busy);
        end
    endtask

    task automatic test_contention();
        int exp_port [3];
        int got;
        logic [133:0] w;
`ifdef LR_ARB_STRICT_PRIO_EN
        exp_port = '{1, 1, 1};
`else
        exp_port = '{0, 1, 0};
`endif
        do_reset();
        bus.p0_req = 1'b1;
        bus.p1_req = 1'b1;
        for (int pkt = 0; pkt < 3; pkt++) begin
            got = -1;
            for (int c = 0; c < 8; c++) begin
                if (bus.p0_gnt === 1'b1) begin got = 0; break; end
                if (bus.p1_gnt === 1'b1) begin got = 1; break; end
                tick();
            end
            n_tests++;
            if (got != exp_port[pkt]) begin
                n_fail++;
                $display("FAIL contention_order%0d: got port %0d expected %0d", pkt, got, exp_port[pkt]);
            end
            if (got >= 0) begin
                for (int i = 0; i < 3; i++) begin
                    w = mkw((i == 0) ? 2'b01 : ((i == 2) ? 2'b10 : 2'b11),
                            32'(got * 256 + pkt * 16 + i));
                    drive(got, 1'b1, w, i == 2, i == 2);
                    tick();
                    n_tests++;
                    if (bus.out_data_wr !== 1'b1 || bus.out_data !== w) begin
                        n_fail++;
                        $display("FAIL contention_word%0d_%0d: got wr=%b data=%h expected wr=1 data=%h",
                                 pkt, i, bus.out_data_wr, bus.out_data, w);
                    end
                end
                drive(got, 1'b0, '0, 1'b0, 1'b0);
                tick();
                n_tests++;
                if (bus.out_data_wr !== 1'b0) begin
                    n_fail++;
                    $display("FAIL contention_gap%0d: got wr=%b expected 0", pkt, bus.out_data_wr);
                end
            end
        end
        bus.p0_req = 1'b0;
        bus.p1_req = 1'b0;
        n_tests++;
`ifdef LR_ARB_STRICT_PRIO_EN
        if (bus.p0_pkt_cnt !== 32'd0 || bus.p1_pkt_cnt !== 32'd3) begin
            n_fail++;
            $display("FAIL contention_cnt: got %0d/%0d expected 0/3", bus.p0_pkt_cnt, bus.p1_pkt_cnt);
        end
`else
        if (bus.p0_pkt_cnt !== 32'd2 || bus.p1_pkt_cnt !== 32'd1) begin
            n_fail++;
            $display("FAIL contention_cnt: got %0d/%0d expected 2/1", bus.p0_pkt_cnt, bus.p1_pkt_cnt);
        end
`endif
    endtask

    task automatic test_stall();
        logic [133:0] syn;
        int bad;
        syn = {2'b10, 132'd0};
        do_reset();
        bus.p1_req = 1'b1;
        tick();
        n_tests++;
        if ({bus.p1_gnt, bus.p0_gnt} !== 2'b10) begin
            n_fail++;
            $display("FAIL stall_grant: got %b expected 10", {bus.p1_gnt, bus.p0_gnt});
        end
        drive(1, 1'b1, mkw(2'b01, 32'h2000), 1'b0, 1'b0);
        tick();
        drive(1, 1'b1, mkw(2'b11, 32'h2001), 1'b0, 1'b0);
        tick();
        n_tests++;
        if (bus.out_data !== mkw(2'b11, 32'h2001)) begin
            n_fail++;
            $display("FAIL stall_body: got %h expected %h", bus.out_data, mkw(2'b11, 32'h2001));
        end
        drive(1, 1'b0, '0, 1'b0, 1'b0);
        bus.p1_req = 1'b0;
        bad = 0;
        for (int s = 1; s <= 16; s++) begin
            tick();
            if (s < 16 && (bus.p1_gnt !== 1'b1 || bus.out_data_wr !== 1'b0)) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL stall_hold: got %0d bad cycles expected 0", bad);
        end
        n_tests++;
        if ({bus.p1_gnt, bus.arb_busy, bus.out_data_wr} !== 3'b010) begin
            n_fail++;
            $display("FAIL stall_fire: got gnt/busy/wr=%b expected 010",
                     {bus.p1_gnt, bus.arb_busy, bus.out_data_wr});
        end
        tick();
        n_tests++;
        if (bus.out_data_wr !== 1'b1 || bus.out_data !== syn ||
            {bus.out_data_valid_wr, bus.out_data_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL stall_tail: got wr=%b data=%h vv=%b expected wr=1 data=%h vv=10",
                     bus.out_data_wr, bus.out_data, {bus.out_data_valid_wr, bus.out_data_valid}, syn);
        end
        n_tests++;
        if (bus.abort_cnt !== 16'd1 || bus.p1_pkt_cnt !== 32'd0 || bus.p1_gnt !== 1'b0 ||
            bus.arb_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_stats: got abort=%0d cnt=%0d gnt=%b busy=%b expected 1 0 0 0",
                     bus.abort_cnt, bus.p1_pkt_cnt, bus.p1_gnt, bus.arb_busy);
        end
    endtask

    task automatic test_hdr_timeout();
        int bad;
        do_reset();
        bus.p0_req = 1'b1;
        tick();
        bus.p1_req = 1'b1;
        bad = 0;
        for (int s = 1; s <= 16; s++) begin
            tick();
            if (s < 16 && bus.p0_gnt !== 1'b1) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL hdr_hold: got %0d early drops expected 0", bad);
        end
        n_tests++;
        if (bus.p0_gnt !== 1'b0 || bus.arb_busy !== 1'b0 || bus.abort_cnt !== 16'd1 ||
            bus.p0_pkt_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL hdr_timeout: got gnt=%b busy=%b abort=%0d cnt=%0d expected 0 0 1 0",
                     bus.p0_gnt, bus.arb_busy, bus.abort_cnt, bus.p0_pkt_cnt);
        end
        bus.p0_req = 1'b0;
        tick();
        n_tests++;
        if ({bus.p1_gnt, bus.p0_gnt} !== 2'b10) begin
            n_fail++;
            $display("FAIL hdr_next: got %b expected 10", {bus.p1_gnt, bus.p0_gnt});
        end
        bus.p1_req = 1'b0;
    endtask

    task automatic test_junk();
        do_reset();
        bus.p0_req = 1'b1;
        drive(1, 1'b1, mkw(2'b01, 32'h9999), 1'b1, 1'b1);
        tick();
        drive(0, 1'b1, mkw(2'b11, 32'h3000), 1'b0, 1'b0);
        tick();
        n_tests++;
        if (bus.out_data_wr !== 1'b0 || bus.arb_busy !== 1'b1 || bus.p0_gnt !== 1'b1) begin
            n_fail++;
            $display("FAIL junk_drop: got wr=%b busy=%b gnt=%b expected 0 1 1",
                     bus.out_data_wr, bus.arb_busy, bus.p0_gnt);
        end
        drive(0, 1'b1, mkw(2'b01, 32'h3001), 1'b0, 1'b0);
        tick();
        n_tests++;
        if (bus.out_data_wr !== 1'b1 || bus.out_data !== mkw(2'b01, 32'h3001)) begin
            n_fail++;
            $display("FAIL junk_head: got wr=%b data=%h expected wr=1 data=%h",
                     bus.out_data_wr, bus.out_data, mkw(2'b01, 32'h3001));
        end
        drive(0, 1'b1, mkw(2'b10, 32'h3002), 1'b1, 1'b1);
        bus.p0_req = 1'b0;
        tick();
        n_tests++;
        if (bus.out_data !== mkw(2'b10, 32'h3002) || bus.p0_pkt_cnt !== 32'd1) begin
            n_fail++;
            $display("FAIL junk_tail: got data=%h cnt=%0d expected data=%h cnt=1",
                     bus.out_data, bus.p0_pkt_cnt, mkw(2'b10, 32'h3002));
        end
        drive(0, 1'b0, '0, 1'b0, 1'b0);
        tick();
        n_tests++;
        if (bus.out_data_wr !== 1'b0 || bus.p1_pkt_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL junk_p1_ignored: got wr=%b p1cnt=%0d expected 0 0",
                     bus.out_data_wr, bus.p1_pkt_cnt);
        end
        drive(1, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.p1_req = 1'b1;
        tick();
        drive(1, 1'b1, mkw(2'b01, 32'h4000), 1'b0, 1'b0);
        tick();
        drive(1, 1'b1, mkw(2'b10, 32'h4001), 1'b1, 1'b1);
        bus.p1_req = 1'b0;
        tick();
        drive(1, 1'b0, '0, 1'b0, 1'b0);
        bus.p0_req = 1'b1;
        tick();
        drive(0, 1'b1, mkw(2'b01, 32'h4100), 1'b0, 1'b0);
        tick();
        drive(0, 1'b1, mkw(2'b11, 32'h4101), 1'b0, 1'b0);
        tick();
        n_tests++;
        if (bus.p1_pkt_cnt !== 32'd1 || bus.out_data_wr !== 1'b1 || bus.arb_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_pre: got p1cnt=%0d wr=%b busy=%b expected 1 1 1",
                     bus.p1_pkt_cnt, bus.out_data_wr, bus.arb_busy);
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({bus.p0_gnt, bus.p1_gnt, bus.out_data_wr, bus.out_data_valid_wr,
             bus.out_data_valid, bus.arb_busy} !== 6'b0 || bus.out_data !== 134'd0) begin
            n_fail++;
            $display("FAIL rstmid_out: got ctrl=%b data=%h expected 0", {bus.p0_gnt, bus.p1_gnt,
                     bus.out_data_wr, bus.out_data_valid_wr, bus.out_data_valid, bus.arb_busy}, bus.out_data);
        end
        n_tests++;
        if ({bus.p0_pkt_cnt, bus.p1_pkt_cnt, bus.abort_cnt} !== 80'd0) begin
            n_fail++;
            $display("FAIL rstmid_cnt: got %h expected 0", {bus.p0_pkt_cnt, bus.p1_pkt_cnt, bus.abort_cnt});
        end
        drive(0, 1'b0, '0, 1'b0, 1'b0);
        bus.p0_req = 1'b1;
        bus.p1_req = 1'b1;
        rst_n = 1'b1;
        tick();
        n_tests++;
        if ({bus.p1_gnt, bus.p0_gnt} !== 2'b01) begin
            n_fail++;
            $display("FAIL rstmid_rearb: got %b expected 01", {bus.p1_gnt, bus.p0_gnt});
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_stall();
        test_hdr_timeout();
        test_junk();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1);
    end

endmodule
